demux_sel_sequencer: RTL
========================

Name: demux_sel_sequencer

Overview:
Upstream driver for the 1x4 demultiplexer. Accepts single-bit transfers over a valid/ready handshake and drives the demux `f`/`sel` inputs. Each bit is held stable for a programmable number of cycles, followed by an idle gap. Destination is addressed per transfer or chosen round-robin, and the block keeps saturating per-channel delivery counters for debug and verification.

Parameters:
HOLD_CYCLES, 4, cycles f/sel stay driven per transfer (legal >=1)
GAP_CYCLES, 1, cycles with f=0 and in_ready=0 after each transfer (legal >=0)
CNT_W, 8, width of each per-channel delivery counter

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  producer has a transfer
in_ready  output  1  block can accept; high only in IDLE
in_data  input  1  bit to route (becomes demux f)
in_dest  input  2  target channel 0..3 (a..d), used when rr_mode=0
rr_mode  input  1  1 = round-robin destination, 0 = in_dest
clr_cnt  input  1  synchronous clear of all counters
f  output  1  demux data input, registered
sel  output  2  demux select, registered
busy  output  1  high in DRIVE or GAP
done  output  1  one-cycle pulse on final DRIVE cycle
cnt_a, cnt_b, cnt_c, cnt_d  output  CNT_W  completed transfers per channel

Behaviour:
- Reset state: rst asserts asynchronously. While rst is high:
  - state=IDLE, f=0, sel=0, busy=0, done=0, rr_ptr=0, all cnt_*=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after release.
- States:
  - IDLE -> DRIVE on accept (in_valid && in_ready at a rising edge).
  - DRIVE -> GAP after HOLD_CYCLES cycles, or DRIVE -> IDLE if GAP_CYCLES=0.
  - GAP -> IDLE after GAP_CYCLES cycles.
- Accept edge:
  - f<=in_data.
  - sel<=(rr_mode ? rr_ptr : in_dest).
  - Load the hold counter.
  - f/sel therefore take their new values at the accept edge, with zero extra latency.
- rr_mode and in_dest are sampled only at the accept edge. Changes during DRIVE/GAP have no effect.
- rr_ptr advances only on accepts with rr_mode=1: +1 modulo 4, wrapping 3->0. Addressed accepts leave rr_ptr unchanged.
- DRIVE:
  - f and sel are held constant for exactly HOLD_CYCLES cycles.
  - done=1 only during the last DRIVE cycle.
  - At the edge ending that cycle, the counter for sel increments, regardless of in_data value.
- End of DRIVE:
  - f<=0.
  - sel holds its last value (no glitch to another channel).
- GAP: f=0, in_ready=0, busy=1.
- Throughput with continuous in_valid: one transfer per 1+HOLD_CYCLES+GAP_CYCLES cycles (IDLE cycle + DRIVE + GAP).
- Handshake: in_valid while in_ready=0 is ignored. The producer must hold in_data/in_dest stable until accepted. There is no combinational path from in_valid to in_ready.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - clr_cnt=1 zeroes all four counters at the next edge.
  - If clr_cnt coincides with an increment, the clear wins (result 0).
- Reset mid-transfer: the transfer is dropped, with no counter increment and no done pulse. Outputs go to reset values immediately, asynchronously to clk.

Test Plan:
1. Addressed sweep (defaults). Sequence, one transfer each, with rr_mode=0:
   - (in_data, in_dest) = (1,0), (1,1), (0,2), (1,3).
   - Required: f/sel = {1,00}, {1,01}, {0,10}, {1,11}, each held 4 cycles, then 1 cycle f=0.
   - done pulses 4 times; each cnt_* ends at 1.
   - Accepts are 6 cycles apart.
2. Round-robin wrap: rr_mode=1, 6 back-to-back transfers with in_dest=3 (ignored).
   - Required: sel = 0, 1, 2, 3, 0, 1.
   - Final counters: cnt_a=2, cnt_b=2, cnt_c=1, cnt_d=1.
3. Backpressure: hold in_valid=1 continuously during DRIVE/GAP.
   - Required: in_ready=0 for 5 cycles after each accept; no extra accept; next accept exactly 6 cycles after the previous one.
4. Saturation and clear, using CNT_W=2:
   - 5 transfers to channel 1 -> cnt_b=3 (saturated).
   - Assert clr_cnt on the edge where a 6th transfer completes -> cnt_b=0.
5. Async reset mid-DRIVE: assert rst between edges on cycle 2 of a transfer to channel 2.
   - Required: f=0, sel=0 immediately, with no done pulse and cnt_c unchanged at 0.
   - After release, in_ready=1 and the next round-robin transfer goes to sel=0.
6. Edge parameters, HOLD_CYCLES=1 and GAP_CYCLES=0:
   - Back-to-back accepts every 2 cycles.
   - f high exactly 1 cycle per transfer; done coincident with that cycle.

Source files
------------

// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer: upstream driver for a 1x4 demultiplexer.
// It accepts one bit per valid/ready handshake and drives the demux f/sel
// inputs for HOLD_CYCLES cycles, then an idle gap of GAP_CYCLES cycles.
// The destination is either addressed per transfer or chosen round-robin.
// Saturating per-channel counters record the completed deliveries.
module demux_sel_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_data,
    input  logic [1:0]       in_dest,
    input  logic             rr_mode,
    input  logic             clr_cnt,
    output logic             f,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q;
    logic [HW-1:0]    hold_q;
    logic [GW-1:0]    gap_q;
    logic [1:0]       rr_ptr_q;
    logic             f_q;
    logic [1:0]       sel_q;
    logic             busy_q;
    logic             done_q;
    logic             ready_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic             drive_end_s;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // The final DRIVE cycle is the one whose hold count has run down to zero.
    assign drive_end_s = (state_q == S_DRIVE) && (hold_q == HW'(0));

    // Transfer sequencer: IDLE/DRIVE/GAP with registered f, sel, busy, done, ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hold_q   <= HW'(0);
            gap_q    <= GW'(0);
            rr_ptr_q <= 2'd0;
            f_q      <= 1'b0;
            sel_q    <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && ready_q) begin
                        // Destination and mode are sampled only here.
                        f_q     <= in_data;
                        sel_q   <= rr_mode ? rr_ptr_q : in_dest;
                        hold_q  <= HOLD_LAST;
                        done_q  <= (HOLD_CYCLES == 1);
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= S_DRIVE;
                        if (rr_mode) begin
                            rr_ptr_q <= rr_ptr_q + 2'd1;
                        end else begin
                            rr_ptr_q <= rr_ptr_q;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (hold_q == HW'(0)) begin
                        // sel keeps its value so the demux never glitches to another channel.
                        f_q    <= 1'b0;
                        done_q <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            gap_q   <= GAP_LAST;
                            state_q <= S_GAP;
                        end
                    end else begin
                        hold_q <= hold_q - HW'(1);
                        done_q <= (hold_q == HW'(1));
                    end
                end
                S_GAP: begin
                    if (gap_q == GW'(0)) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    f_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Delivery counters: clear has priority over the completion increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (clr_cnt) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (drive_end_s) begin
            cnt_q[sel_q] <= sat_inc(cnt_q[sel_q]);
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_q[i];
            end
        end
    end

    assign in_ready = ready_q;
    assign f        = f_q;
    assign sel      = sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cnt_a    = cnt_q[0];
    assign cnt_b    = cnt_q[1];
    assign cnt_c    = cnt_q[2];
    assign cnt_d    = cnt_q[3];

endmodule
